// File: rtl/gb_pkg.sv
// Shared types for the global-buffer bank scheduler: bank counts,
// bank-index types and the scheduler FSM state encoding.
package gb_pkg;

  localparam int GB_NUM_ACT_BANK = 3;
  localparam int GB_NUM_WGT_BANK = 2;

  typedef logic [$clog2(GB_NUM_ACT_BANK)-1:0] act_sel_t;
  typedef logic [$clog2(GB_NUM_WGT_BANK)-1:0] wgt_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_ROTATE,
    ST_FINISH
  } sched_state_t;

endpackage

// File: rtl/gb_role_rotator.sv
// Register ring holding one bank index per role. On each rotate strobe
// role i takes the bank previously held by role i+1 (wrapping), so with
// three roles r<-w, w<-d, d<-r, and with two roles the pair swaps.
// After reset role i holds bank i.
module gb_role_rotator #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                rotate,
  output logic [N-1:0][W-1:0] sel
);

  logic [N-1:0][W-1:0] sel_reg;

  // Load identity mapping on reset, shift the ring by one role per strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        sel_reg[i] <= W'(i);
      end
    end else if (rotate) begin
      for (int i = 0; i < N; i++) begin
        sel_reg[i] <= sel_reg[(i + 1) % N];
      end
    end
  end

  assign sel = sel_reg;

endmodule

// File: rtl/act_bank_sched.sv
// Layer-by-layer scheduler for a triple-buffered activation store and a
// double-buffered weight store. Each layer launches MAC and DRAM work
// together, waits for both completions, then rotates bank roles.
module act_bank_sched
  import gb_pkg::*;
#(
  parameter int NUM_ACT_BANK = GB_NUM_ACT_BANK,
  parameter int NUM_WGT_BANK = GB_NUM_WGT_BANK,
  parameter int LAYER_W      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LAYER_W-1:0] cfg_layers,
  output logic               mac_go,
  input  logic               mac_done,
  output logic               dram_go,
  input  logic               dram_done,
  output act_sel_t           act_rsel,
  output act_sel_t           act_wsel,
  output act_sel_t           act_dsel,
  output wgt_sel_t           wgt_rsel,
  output wgt_sel_t           wgt_wsel,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done
);

  sched_state_t       state_reg;
  logic               cfg_ready_reg;
  logic               go_reg;
  logic               done_reg;
  logic               busy_reg;
  logic               mac_seen_reg;
  logic               dram_seen_reg;
  logic [LAYER_W-1:0] layer_idx_reg;
  logic [LAYER_W-1:0] cfg_layers_reg;
  logic [LAYER_W:0]   layer_idx_inc;
  logic               pair_done;
  logic               rotate;

  logic [NUM_ACT_BANK-1:0][$bits(act_sel_t)-1:0] act_sel;
  logic [NUM_WGT_BANK-1:0][$bits(wgt_sel_t)-1:0] wgt_sel;

  // One extra bit so the last layer of a full-range job cannot wrap.
  assign layer_idx_inc = {1'b0, layer_idx_reg} + (LAYER_W + 1)'(1);
  // Completion of the pair counts a pulse arriving in this very cycle.
  assign pair_done     = (mac_seen_reg | mac_done) & (dram_seen_reg | dram_done);
  assign rotate        = (state_reg == ST_ROTATE);

  // Scheduler FSM with all handshake outputs registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cfg_ready_reg  <= 1'b1;
      go_reg         <= 1'b0;
      done_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      mac_seen_reg   <= 1'b0;
      dram_seen_reg  <= 1'b0;
      layer_idx_reg  <= '0;
      cfg_layers_reg <= '0;
    end else begin
      go_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cfg_valid) begin
            cfg_layers_reg <= cfg_layers;
            layer_idx_reg  <= '0;
            cfg_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            if (cfg_layers != '0) begin
              state_reg <= ST_LAUNCH;
              go_reg    <= 1'b1;
            end else begin
              state_reg <= ST_FINISH;
              done_reg  <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          mac_seen_reg  <= 1'b0;
          dram_seen_reg <= 1'b0;
          state_reg     <= ST_RUN;
        end
        ST_RUN: begin
          mac_seen_reg  <= mac_seen_reg | mac_done;
          dram_seen_reg <= dram_seen_reg | dram_done;
          if (pair_done) begin
            state_reg <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          layer_idx_reg <= layer_idx_inc[LAYER_W-1:0];
          if (layer_idx_inc < {1'b0, cfg_layers_reg}) begin
            state_reg <= ST_LAUNCH;
            go_reg    <= 1'b1;
          end else begin
            state_reg <= ST_FINISH;
            done_reg  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_reg     <= ST_IDLE;
          cfg_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
        default: begin
          state_reg     <= ST_IDLE;
          cfg_ready_reg <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  gb_role_rotator #(
    .N(NUM_ACT_BANK),
    .W($bits(act_sel_t))
  ) u_act_rot (
    .clock (clock),
    .reset (reset),
    .rotate(rotate),
    .sel   (act_sel)
  );

  gb_role_rotator #(
    .N(NUM_WGT_BANK),
    .W($bits(wgt_sel_t))
  ) u_wgt_rot (
    .clock (clock),
    .reset (reset),
    .rotate(rotate),
    .sel   (wgt_sel)
  );

  assign cfg_ready = cfg_ready_reg;
  assign mac_go    = go_reg;
  assign dram_go   = go_reg;
  assign done      = done_reg;
  assign busy      = busy_reg;
  assign layer_idx = layer_idx_reg;
  assign act_rsel  = act_sel[0];
  assign act_wsel  = act_sel[1];
  assign act_dsel  = act_sel[2];
  assign wgt_rsel  = wgt_sel[0];
  assign wgt_wsel  = wgt_sel[1];

endmodule

// File: tb/tb_act_bank_sched.sv
// Bench for act_bank_sched. The reference model tracks only the number of
// completed layers since reset: bank roles follow from that count modulo
// the bank counts, and handshake timing follows from the job shape.
module tb_act_bank_sched;

  localparam int LAYER_W = 8;

  // {mac_go, dram_go, done, busy, cfg_ready}
  localparam logic [4:0] C_IDLE   = 5'b00001;
  localparam logic [4:0] C_LAUNCH = 5'b11010;
  localparam logic [4:0] C_RUN    = 5'b00010;
  localparam logic [4:0] C_FINISH = 5'b00110;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [LAYER_W-1:0] cfg_layers = '0;
  logic               mac_go;
  logic               mac_done = 1'b0;
  logic               dram_go;
  logic               dram_done = 1'b0;
  logic [1:0]         act_rsel, act_wsel, act_dsel;
  logic               wgt_rsel, wgt_wsel;
  logic [LAYER_W-1:0] layer_idx;
  logic               busy;
  logic               done;

  logic [4:0] ctl_obs;
  logic [7:0] sels_obs;

  int checks  = 0;
  int errors  = 0;
  int rot_cnt = 0;

  assign ctl_obs  = {mac_go, dram_go, done, busy, cfg_ready};
  assign sels_obs = {act_rsel, act_wsel, act_dsel, wgt_rsel, wgt_wsel};

  act_bank_sched #(
    .NUM_ACT_BANK(3),
    .NUM_WGT_BANK(2),
    .LAYER_W     (LAYER_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_layers(cfg_layers),
    .mac_go    (mac_go),
    .mac_done  (mac_done),
    .dram_go   (dram_go),
    .dram_done (dram_done),
    .act_rsel  (act_rsel),
    .act_wsel  (act_wsel),
    .act_dsel  (act_dsel),
    .wgt_rsel  (wgt_rsel),
    .wgt_wsel  (wgt_wsel),
    .layer_idx (layer_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bank roles after rot_cnt rotations from the reset mapping.
  function automatic logic [7:0] exp_sels();
    int k;
    k = rot_cnt;
    return {2'(k % 3), 2'((k + 1) % 3), 2'((k + 2) % 3), 1'(k % 2), 1'((k + 1) % 2)};
  endfunction

  // Runs one job from an IDLE cycle to the IDLE cycle after done.
  // dm_fix/dd_fix > 0 fix the RUN-cycle of mac_done/dram_done, else random
  // with random repeats and noise outside RUN. spam adds two repeats of mac_done.
  task automatic run_job(input int layers, input int dm_fix, input int dd_fix,
                         input bit spam, input bit hold);
    int dm, dd, last;
    bit noisy;
    noisy = (dm_fix <= 0);
    checks++;
    if (ctl_obs !== C_IDLE) begin
      errors++;
      $display("FAIL accept_idle: got %b expected %b", ctl_obs, C_IDLE);
    end
    cfg_valid  = 1'b1;
    cfg_layers = LAYER_W'(layers);
    tick();
    if (!hold) cfg_valid = 1'b0;
    cfg_layers = LAYER_W'($urandom);
    for (int l = 0; l < layers; l++) begin
      checks++;
      if (ctl_obs !== C_LAUNCH) begin
        errors++;
        $display("FAIL launch_ctl layer %0d: got %b expected %b", l, ctl_obs, C_LAUNCH);
      end
      checks++;
      if (layer_idx !== LAYER_W'(l)) begin
        errors++;
        $display("FAIL launch_layer_idx: got %0d expected %0d", layer_idx, l);
      end
      checks++;
      if (sels_obs !== exp_sels()) begin
        errors++;
        $display("FAIL launch_sels layer %0d: got %b expected %b", l, sels_obs, exp_sels());
      end
      mac_done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      dram_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      dm = (dm_fix > 0) ? dm_fix : int'($urandom_range(1, 6));
      dd = (dd_fix > 0) ? dd_fix : int'($urandom_range(1, 6));
      last = (dm > dd) ? dm : dd;
      tick();
      for (int c = 1; c <= last; c++) begin
        mac_done  = (c == dm) || (c > dm && ((spam && c <= dm + 2) ||
                                             (noisy && $urandom_range(0, 2) == 0)));
        dram_done = (c == dd) || (c > dd && noisy && $urandom_range(0, 2) == 0);
        checks++;
        if (ctl_obs !== C_RUN) begin
          errors++;
          $display("FAIL run_ctl layer %0d cycle %0d: got %b expected %b", l, c, ctl_obs, C_RUN);
        end
        tick();
      end
      mac_done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      dram_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      checks++;
      if (ctl_obs !== C_RUN) begin
        errors++;
        $display("FAIL rotate_ctl layer %0d: got %b expected %b", l, ctl_obs, C_RUN);
      end
      checks++;
      if (sels_obs !== exp_sels()) begin
        errors++;
        $display("FAIL rotate_sels layer %0d: got %b expected %b", l, sels_obs, exp_sels());
      end
      rot_cnt++;
      tick();
    end
    mac_done  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    dram_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    checks++;
    if (ctl_obs !== C_FINISH) begin
      errors++;
      $display("FAIL finish_ctl: got %b expected %b", ctl_obs, C_FINISH);
    end
    checks++;
    if (layer_idx !== LAYER_W'(layers)) begin
      errors++;
      $display("FAIL finish_layer_idx: got %0d expected %0d", layer_idx, layers);
    end
    checks++;
    if (sels_obs !== exp_sels()) begin
      errors++;
      $display("FAIL finish_sels: got %b expected %b", sels_obs, exp_sels());
    end
    tick();
    mac_done  = 1'b0;
    dram_done = 1'b0;
    checks++;
    if (ctl_obs !== C_IDLE) begin
      errors++;
      $display("FAIL end_idle_ctl: got %b expected %b", ctl_obs, C_IDLE);
    end
    $display("job layers=%0d hold=%0d rotations=%0d checks=%0d errors=%0d",
             layers, hold, rot_cnt, checks, errors);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    cfg_valid = 1'b0;
    mac_done  = 1'b0;
    dram_done = 1'b0;
    tick();
    tick();
    rot_cnt = 0;
    checks++;
    if (ctl_obs !== C_IDLE) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected %b", ctl_obs, C_IDLE);
    end
    checks++;
    if (layer_idx !== '0) begin
      errors++;
      $display("FAIL reset_layer_idx: got %0d expected 0", layer_idx);
    end
    checks++;
    if (sels_obs !== 8'b00011001) begin
      errors++;
      $display("FAIL reset_sels: got %b expected %b", sels_obs, 8'b00011001);
    end
    reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic test_single_layer();
    run_job(1, 4, 8, 1'b0, 1'b0);
    checks++;
    if (sels_obs !== 8'b01100010) begin
      errors++;
      $display("FAIL single_layer_sels: got %b expected %b", sels_obs, 8'b01100010);
    end
  endtask

  task automatic test_same_cycle();
    test_reset();
    run_job(3, 1, 1, 1'b0, 1'b0);
    checks++;
    if (sels_obs !== 8'b00011010) begin
      errors++;
      $display("FAIL same_cycle_sels: got %b expected %b", sels_obs, 8'b00011010);
    end
  endtask

  task automatic test_zero_layers();
    run_job(0, 1, 1, 1'b0, 1'b0);
  endtask

  task automatic test_spurious();
    run_job(1, 2, 9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      mac_done  = 1'b1;
      dram_done = (i == 2);
      tick();
      checks++;
      if (ctl_obs !== C_IDLE) begin
        errors++;
        $display("FAIL stray_idle_ctl: got %b expected %b", ctl_obs, C_IDLE);
      end
      checks++;
      if (sels_obs !== exp_sels()) begin
        errors++;
        $display("FAIL stray_idle_sels: got %b expected %b", sels_obs, exp_sels());
      end
    end
    mac_done  = 1'b0;
    dram_done = 1'b0;
    run_job(1, 3, 5, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    cfg_valid  = 1'b1;
    cfg_layers = LAYER_W'(4);
    tick();
    cfg_valid = 1'b0;
    tick();
    mac_done  = 1'b1;
    dram_done = 1'b1;
    tick();
    mac_done  = 1'b0;
    dram_done = 1'b0;
    rot_cnt++;
    tick();
    checks++;
    if (ctl_obs !== C_LAUNCH || layer_idx !== LAYER_W'(1)) begin
      errors++;
      $display("FAIL mid_launch2: got ctl %b idx %0d expected ctl %b idx 1", ctl_obs, layer_idx, C_LAUNCH);
    end
    tick();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    reset    = 1'b1;
    tick();
    reset   = 1'b0;
    rot_cnt = 0;
    checks++;
    if (ctl_obs !== C_IDLE || layer_idx !== '0) begin
      errors++;
      $display("FAIL mid_reset_state: got ctl %b idx %0d expected ctl %b idx 0", ctl_obs, layer_idx, C_IDLE);
    end
    checks++;
    if (sels_obs !== 8'b00011001) begin
      errors++;
      $display("FAIL mid_reset_sels: got %b expected %b", sels_obs, 8'b00011001);
    end
    for (int i = 0; i < 4; i++) begin
      mac_done  = 1'(i % 2);
      dram_done = 1'b1;
      tick();
      checks++;
      if (ctl_obs !== C_IDLE) begin
        errors++;
        $display("FAIL post_reset_idle: got %b expected %b", ctl_obs, C_IDLE);
      end
    end
    mac_done  = 1'b0;
    dram_done = 1'b0;
    $display("reset mid-job applied");
    run_job(4, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_job(2, 0, 0, 1'b0, 1'b1);
    run_job(1, 0, 0, 1'b0, 1'b1);
    run_job(0, 0, 0, 1'b0, 1'b1);
    run_job(2, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 10; j++) begin
      run_job(int'($urandom_range(0, 6)), 0, 0, 1'b0,
              (j < 9) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic test_max_layers();
    run_job(255, 1, 1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_same_cycle();
    test_zero_layers();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_max_layers();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
